// File: rtl/instruction_memory_stream_pkg.sv
// rtl/instruction_memory_stream_pkg.sv - shared defaults, FSM state encoding and clear helper
package instruction_memory_stream_pkg;

  localparam int BYTE_SIZE = 8;

  localparam int DEFAULT_INSTRUCTION_MEMORY_PC_BUS_SIZE        = 32;
  localparam int DEFAULT_INSTRUCTION_MEMORY_WORD_SIZE_IN_BYTES = 4;
  localparam int DEFAULT_INSTRUCTION_MEMORY_MEM_SIZE_IN_WORDS  = 64;
  localparam int DEFAULT_INSTRUCTION_MEMORY_NOP_WORD           = 0;

  typedef enum logic [1:0] {
    IMS_STATE_IDLE     = 2'b00,
    IMS_STATE_ASSEMBLE = 2'b01,
    IMS_STATE_FULL     = 2'b10
  } ims_state_t;

  // Program clear and reset have identical effect everywhere in the block.
  function automatic logic ims_clear(input logic reset, input logic clear);
    return reset | clear;
  endfunction

endpackage

// File: rtl/instruction_memory_stream_if.sv
// rtl/instruction_memory_stream_if.sv - load/read/status bus of the instruction memory
interface instruction_memory_stream_if
  import instruction_memory_stream_pkg::*;
#(
  parameter int PC_BUS_SIZE        = DEFAULT_INSTRUCTION_MEMORY_PC_BUS_SIZE,
  parameter int WORD_SIZE_IN_BYTES = DEFAULT_INSTRUCTION_MEMORY_WORD_SIZE_IN_BYTES,
  parameter int MEM_SIZE_IN_WORDS  = DEFAULT_INSTRUCTION_MEMORY_MEM_SIZE_IN_WORDS
);
  localparam int WORD_W  = BYTE_SIZE * WORD_SIZE_IN_BYTES;
  localparam int COUNT_W = $clog2(MEM_SIZE_IN_WORDS + 1);

  logic                   i_byte_valid;
  logic [BYTE_SIZE-1:0]   i_byte;
  logic                   o_byte_ready;
  logic                   i_word_write;
  logic [WORD_W-1:0]      i_word;
  logic [PC_BUS_SIZE-1:0] i_pc;
  logic [WORD_W-1:0]      o_instruction;
  logic                   o_pc_fault;
  logic                   o_full;
  logic                   o_empty;
  logic                   o_partial;
  logic [COUNT_W-1:0]     o_word_count;

  modport master (
    output i_byte_valid, i_byte, i_word_write, i_word, i_pc,
    input  o_byte_ready, o_instruction, o_pc_fault, o_full, o_empty, o_partial, o_word_count
  );

  modport slave (
    input  i_byte_valid, i_byte, i_word_write, i_word, i_pc,
    output o_byte_ready, o_instruction, o_pc_fault, o_full, o_empty, o_partial, o_word_count
  );

endinterface

// File: rtl/instruction_memory_stream_byte_word_assembler.sv
// rtl/instruction_memory_stream_byte_word_assembler.sv - little-endian byte-to-word packer
module instruction_memory_stream_byte_word_assembler
  import instruction_memory_stream_pkg::*;
#(
  parameter int WORD_SIZE_IN_BYTES = DEFAULT_INSTRUCTION_MEMORY_WORD_SIZE_IN_BYTES
) (
  input  logic                                    i_clk,
  input  logic                                    i_reset,
  input  logic                                    i_byte_accept,
  input  logic [BYTE_SIZE-1:0]                    i_byte,
  output logic                                    o_word_valid,
  output logic [BYTE_SIZE*WORD_SIZE_IN_BYTES-1:0] o_word
);
  localparam int CW = $clog2(WORD_SIZE_IN_BYTES);

  logic [CW-1:0]                             r_count;
  logic [BYTE_SIZE*(WORD_SIZE_IN_BYTES-1)-1:0] r_assembly;
  logic                                      w_last;

  assign w_last = (r_count == CW'(WORD_SIZE_IN_BYTES - 1));

  // The final byte bypasses the register so the word is complete on the same edge.
  assign o_word_valid = i_byte_accept && w_last;
  assign o_word       = {i_byte, r_assembly};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count    <= '0;
      r_assembly <= '0;
    end else if (i_byte_accept) begin
      if (w_last) begin
        r_count    <= '0;
        r_assembly <= '0;
      end else begin
        r_count <= r_count + 1'b1;
        for (int k = 0; k < WORD_SIZE_IN_BYTES - 1; k++) begin
          if (r_count == CW'(k)) begin
            r_assembly[BYTE_SIZE*k +: BYTE_SIZE] <= i_byte;
          end
        end
      end
    end
  end

endmodule

// File: rtl/instruction_memory_stream.sv
// rtl/instruction_memory_stream.sv - stream/word loaded instruction memory with PC read port
// Optional registered read port: INSTRUCTION_MEMORY_REGISTERED_READ_EN.
module instruction_memory_stream
  import instruction_memory_stream_pkg::*;
#(
  parameter int PC_BUS_SIZE        = DEFAULT_INSTRUCTION_MEMORY_PC_BUS_SIZE,
  parameter int WORD_SIZE_IN_BYTES = DEFAULT_INSTRUCTION_MEMORY_WORD_SIZE_IN_BYTES,
  parameter int MEM_SIZE_IN_WORDS  = DEFAULT_INSTRUCTION_MEMORY_MEM_SIZE_IN_WORDS,
  parameter logic [BYTE_SIZE*WORD_SIZE_IN_BYTES-1:0] NOP_WORD =
    (BYTE_SIZE*WORD_SIZE_IN_BYTES)'(DEFAULT_INSTRUCTION_MEMORY_NOP_WORD)
) (
  input logic                         i_clk,
  input logic                         i_reset,
  input logic                         i_clear,
  instruction_memory_stream_if.slave  bus
);
  localparam int WORD_W  = BYTE_SIZE * WORD_SIZE_IN_BYTES;
  localparam int AW      = $clog2(MEM_SIZE_IN_WORDS);
  localparam int OFF     = $clog2(WORD_SIZE_IN_BYTES);
  localparam int COUNT_W = $clog2(MEM_SIZE_IN_WORDS + 1);
  localparam logic [PC_BUS_SIZE:0] LIMIT =
    (PC_BUS_SIZE+1)'(MEM_SIZE_IN_WORDS * WORD_SIZE_IN_BYTES);

  logic [WORD_W-1:0]  r_mem [MEM_SIZE_IN_WORDS];
  ims_state_t         r_state;
  logic [COUNT_W-1:0] r_index;

  logic               w_clear;
  logic               w_byte_ready;
  logic               w_byte_accept;
  logic               w_last_slot;
  logic [AW-1:0]      w_wr_addr;
  logic               w_asm_valid;
  logic [WORD_W-1:0]  w_asm_word;
  logic               w_rd_fault;
  logic [AW-1:0]      w_rd_addr;
  logic [WORD_W-1:0]  w_rd_word;

  assign w_clear       = ims_clear(i_reset, i_clear);
  assign w_byte_ready  = (r_state != IMS_STATE_FULL) && !bus.i_word_write;
  assign w_byte_accept = bus.i_byte_valid && w_byte_ready;
  assign w_last_slot   = (r_index == COUNT_W'(MEM_SIZE_IN_WORDS - 1));
  assign w_wr_addr     = r_index[AW-1:0];

  instruction_memory_stream_byte_word_assembler #(
    .WORD_SIZE_IN_BYTES (WORD_SIZE_IN_BYTES)
  ) u_assembler (
    .i_clk         (i_clk),
    .i_reset       (w_clear),
    .i_byte_accept (w_byte_accept),
    .i_byte        (bus.i_byte),
    .o_word_valid  (w_asm_valid),
    .o_word        (w_asm_word)
  );

  // Fill FSM: the direct word port is only honoured between stream words.
  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_state <= IMS_STATE_IDLE;
      r_index <= '0;
      for (int i = 0; i < MEM_SIZE_IN_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        IMS_STATE_IDLE: begin
          if (bus.i_word_write) begin
            r_mem[w_wr_addr] <= bus.i_word;
            r_index          <= r_index + 1'b1;
            r_state          <= w_last_slot ? IMS_STATE_FULL : IMS_STATE_IDLE;
          end else if (w_byte_accept) begin
            r_state <= IMS_STATE_ASSEMBLE;
          end
        end
        IMS_STATE_ASSEMBLE: begin
          if (w_asm_valid) begin
            r_mem[w_wr_addr] <= w_asm_word;
            r_index          <= r_index + 1'b1;
            r_state          <= w_last_slot ? IMS_STATE_FULL : IMS_STATE_IDLE;
          end
        end
        IMS_STATE_FULL: begin
          r_state <= IMS_STATE_FULL;
        end
        default: begin
          r_state <= IMS_STATE_IDLE;
        end
      endcase
    end
  end

  assign bus.o_byte_ready = w_byte_ready;
  assign bus.o_full       = (r_state == IMS_STATE_FULL);
  assign bus.o_partial    = (r_state == IMS_STATE_ASSEMBLE);
  assign bus.o_word_count = r_index;
  assign bus.o_empty      = (r_index == '0);

  assign w_rd_fault = (|bus.i_pc[OFF-1:0]) || ({1'b0, bus.i_pc} >= LIMIT);
  assign w_rd_addr  = bus.i_pc[OFF +: AW];
  assign w_rd_word  = w_rd_fault ? NOP_WORD : r_mem[w_rd_addr];

`ifdef INSTRUCTION_MEMORY_REGISTERED_READ_EN
  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      bus.o_instruction <= NOP_WORD;
      bus.o_pc_fault    <= 1'b0;
    end else begin
      bus.o_instruction <= w_rd_word;
      bus.o_pc_fault    <= w_rd_fault;
    end
  end
`else
  assign bus.o_instruction = w_rd_word;
  assign bus.o_pc_fault    = w_rd_fault;
`endif

endmodule

// File: tb/tb_instruction_memory_stream.sv
// tb/tb_instruction_memory_stream.sv - self-checking bench for instruction_memory_stream (4-byte words, 4 words)
module tb_instruction_memory_stream;
  import instruction_memory_stream_pkg::*;

  localparam int MEM = 4;
  localparam int WB  = 4;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  always #5 clk = ~clk;

  instruction_memory_stream_if #(
    .PC_BUS_SIZE        (32),
    .WORD_SIZE_IN_BYTES (WB),
    .MEM_SIZE_IN_WORDS  (MEM)
  ) bus ();

  instruction_memory_stream #(
    .PC_BUS_SIZE        (32),
    .WORD_SIZE_IN_BYTES (WB),
    .MEM_SIZE_IN_WORDS  (MEM),
    .NOP_WORD           (32'h0)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_clear (clr),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: a word array, a count of stored words and a list of pending bytes.
  logic [31:0] m_mem [MEM];
  logic [7:0]  m_bytes [WB];
  int          m_count  = 0;
  int          m_nbytes = 0;
  bit          m_valid  = 1'b0;
  logic [31:0] m_rd_instr;
  logic        m_rd_fault;

  function automatic logic exp_fault(input logic [31:0] pc);
    return (pc % WB != 0) || (pc >= MEM * WB);
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] pc);
    if (exp_fault(pc)) return 32'h0;
    return m_mem[pc / WB];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all();
    if (!m_valid) return;
    check("byte_ready", 32'(bus.o_byte_ready), 32'((m_count < MEM) && !bus.i_word_write));
    check("full", 32'(bus.o_full), 32'(m_count == MEM));
    check("empty", 32'(bus.o_empty), 32'(m_count == 0));
    check("partial", 32'(bus.o_partial), 32'(m_nbytes != 0));
    check("word_count", 32'(bus.o_word_count), 32'(m_count));
`ifdef INSTRUCTION_MEMORY_REGISTERED_READ_EN
    check("pc_fault", 32'(bus.o_pc_fault), 32'(m_rd_fault));
    check("instruction", bus.o_instruction, m_rd_instr);
`else
    check("pc_fault", 32'(bus.o_pc_fault), 32'(exp_fault(bus.i_pc)));
    check("instruction", bus.o_instruction, exp_read(bus.i_pc));
`endif
  endtask

  task automatic model_step();
    if (rst || clr) begin
      for (int i = 0; i < MEM; i++) m_mem[i] = 32'h0;
      m_count    = 0;
      m_nbytes   = 0;
      m_valid    = 1'b1;
      m_rd_instr = 32'h0;
      m_rd_fault = 1'b0;
      return;
    end
    m_rd_fault = exp_fault(bus.i_pc);
    m_rd_instr = exp_read(bus.i_pc);
    if (bus.i_word_write) begin
      if (m_nbytes == 0 && m_count < MEM) begin
        m_mem[m_count] = bus.i_word;
        m_count++;
      end
    end else if (bus.i_byte_valid && m_count < MEM) begin
      m_bytes[m_nbytes] = bus.i_byte;
      m_nbytes++;
      if (m_nbytes == WB) begin
        m_mem[m_count] = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
        m_count++;
        m_nbytes = 0;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_byte_valid = 1'b1;
    bus.i_byte       = b;
    tick();
    bus.i_byte_valid = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] w);
    bus.i_word_write = 1'b1;
    bus.i_word       = w;
    tick();
    bus.i_word_write = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [31:0] pc,
                            input logic [31:0] instr, input logic fault);
    bus.i_pc = pc;
    tick();
    check({name, "_instr"}, bus.o_instruction, instr);
    check({name, "_fault"}, 32'(bus.o_pc_fault), 32'(fault));
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    bus.i_byte_valid = 1'b0;
    bus.i_byte       = 8'h0;
    bus.i_word_write = 1'b0;
    bus.i_word       = 32'h0;
    bus.i_pc         = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_empty", 32'(bus.o_empty), 32'd1);
    check("rst_full", 32'(bus.o_full), 32'd0);
    check("rst_partial", 32'(bus.o_partial), 32'd0);
    check("rst_count", 32'(bus.o_word_count), 32'd0);

    // Stream one little-endian word.
    send_byte(8'h78);
    check("s1_partial", 32'(bus.o_partial), 32'd1);
    check("s1_empty", 32'(bus.o_empty), 32'd1);
    send_byte(8'h56);
    send_byte(8'h34);
    check("s3_partial", 32'(bus.o_partial), 32'd1);
    send_byte(8'h12);
    check("s4_partial", 32'(bus.o_partial), 32'd0);
    check("s4_count", 32'(bus.o_word_count), 32'd1);
    check("s4_empty", 32'(bus.o_empty), 32'd0);
    read_check("s4_pc0", 32'd0, 32'h12345678, 1'b0);

    // Direct writes up to FULL, read-during-write on pc 0 covered by the compare.
    do_clear();
    bus.i_pc = 32'd0;
    for (int i = 1; i <= 4; i++) write_word(32'hAAAA0000 + 32'(i));
    check("dw_full", 32'(bus.o_full), 32'd1);
    check("dw_count", 32'(bus.o_word_count), 32'd4);
    check("dw_ready", 32'(bus.o_byte_ready), 32'd0);
    write_word(32'hBBBBBBBB);
    check("dw5_count", 32'(bus.o_word_count), 32'd4);
    read_check("dw_pc12", 32'd12, 32'hAAAA0004, 1'b0);
    read_check("pc16", 32'd16, 32'h0, 1'b1);
    read_check("pc2", 32'd2, 32'h0, 1'b1);
    read_check("pc4", 32'd4, 32'hAAAA0002, 1'b0);
    bus.i_byte_valid = 1'b1;
    bus.i_byte       = 8'hEE;
    tick();
    tick();
    bus.i_byte_valid = 1'b0;
    check("full_hold_count", 32'(bus.o_word_count), 32'd4);

    // Word write during assembly is ignored.
    do_clear();
    send_byte(8'h11);
    send_byte(8'h22);
    write_word(32'hDEADBEEF);
    check("asm_ww_count", 32'(bus.o_word_count), 32'd0);
    check("asm_ww_partial", 32'(bus.o_partial), 32'd1);
    send_byte(8'h33);
    send_byte(8'h44);
    read_check("asm_pc0", 32'd0, 32'h44332211, 1'b0);

    // Word write and byte in the same IDLE cycle: word wins, byte is held.
    do_clear();
    bus.i_word_write = 1'b1;
    bus.i_word       = 32'h5555AAAA;
    bus.i_byte_valid = 1'b1;
    bus.i_byte       = 8'h99;
    #1;
    check("both_ready", 32'(bus.o_byte_ready), 32'd0);
    tick();
    bus.i_word_write = 1'b0;
    check("both_count", 32'(bus.o_word_count), 32'd1);
    check("both_partial", 32'(bus.o_partial), 32'd0);
    tick();
    bus.i_byte_valid = 1'b0;
    check("held_partial", 32'(bus.o_partial), 32'd1);
    send_byte(8'h88);
    send_byte(8'h77);
    send_byte(8'h66);
    read_check("both_pc4", 32'd4, 32'h66778899, 1'b0);
    read_check("both_pc0", 32'd0, 32'h5555AAAA, 1'b0);

    // Clear in the middle of assembly discards the partial bytes.
    do_clear();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    do_clear();
    check("clr_partial", 32'(bus.o_partial), 32'd0);
    check("clr_empty", 32'(bus.o_empty), 32'd1);
    for (int i = 0; i < MEM; i++) read_check("clr_rd", 32'(i * 4), 32'h0, 1'b0);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    read_check("clr_pc0", 32'd0, 32'hD4C3B2A1, 1'b0);

    // Fill entirely from the stream.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < MEM * WB; i++) send_byte(8'(i));
    check("sfill_full", 32'(bus.o_full), 32'd1);
    check("sfill_count", 32'(bus.o_word_count), 32'd4);
    read_check("sfill_pc8", 32'd8, 32'h0B0A0908, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
